accum_controller: RTL
=====================

Name: accum_controller

Overview:
- Instruction sequencer for the 8-bit accumulator CPU. It drives the ALU's 3-bit opcode and consumes the ALU's a_is_zero flag.
- Owns the program counter (PC), the instruction register (IR) and an 8-phase cycle counter. It issues memory read/write strobes, accumulator load and bus-drive enables.
- Sits between instruction/data memory and the ALU/accumulator datapath.

Parameters:
- WIDTH, 8, memory data and instruction width; instruction = {opcode[2:0], address}.
- AWIDTH, 5, memory address width; opcode occupies IR[WIDTH-1:WIDTH-3], operand address occupies IR[AWIDTH-1:0]; WIDTH >= AWIDTH+3 required.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- mem_rdata  input  WIDTH  memory read data (instruction fetch)
- a_is_zero  input  1  ALU flag: accumulator equals zero
- opcode  output  3  IR opcode field to ALU
- mem_addr  output  AWIDTH  PC when sel=1, IR address field when sel=0
- mem_rd  output  1  memory read strobe
- mem_wr  output  1  memory write strobe
- data_e  output  1  accumulator drives memory data bus
- ld_ac  output  1  accumulator captures alu_out at end of cycle
- halt  output  1  processor halted

Behaviour:
- Opcode decode: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP. ALUOP = ADD|AND|XOR|LDA.
- Reset, rst=1 at clk edge: phase=0, PC=0, IR=0, halted=0. Resulting outputs: opcode=0, mem_addr=0, mem_rd=0, mem_wr=0, data_e=0, ld_ac=0, halt=0. rst overrides everything, including mid-instruction and while halted.
- Phase counter advances 0..7 then wraps to 0, +1 per clk, unless halted. One instruction every 8 cycles.
- Outputs are combinational from phase and IR, except halt.
- Strobe outputs not listed for a phase are 0.
- Phase 0, INST_ADDR: sel=1.
- Phase 1, INST_FETCH: sel=1, mem_rd=1.
- Phase 2, INST_LOAD: sel=1, mem_rd=1; IR <= mem_rdata at end of cycle.
- Phase 3, IDLE: sel=1, mem_rd=1.
- Phase 4, OP_ADDR: sel=0; PC <= PC+1 at end of cycle. If opcode==HLT, halted <= 1 at end of cycle.
- Phase 5, OP_FETCH: mem_rd = ALUOP.
- Phase 6, ALU_OP:
  - mem_rd = ALUOP.
  - SKZ: if a_is_zero==1, PC <= PC+1 at end of cycle (skip).
  - JMP: PC <= IR address at end of cycle.
  - STO: data_e=1.
- Phase 7, STORE:
  - ALUOP: mem_rd=1, ld_ac=1.
  - JMP: PC <= IR address again (idempotent).
  - STO: mem_wr=1, data_e=1.
- a_is_zero is sampled only in phase 6. Its value in all other phases is ignored.
- PC arithmetic is modulo 2^AWIDTH: PC=2^AWIDTH-1 plus 1 gives 0, for both the phase-4 increment and the SKZ skip.
- Increment and load of PC never coincide: SKZ and JMP are exclusive opcodes.
- halt = halted register OR (phase==4 AND opcode==HLT), so halt rises in phase 4.
- While halted:
  - phase is frozen at 5; PC, IR and the phase counter hold.
  - mem_rd=0, mem_wr=0, data_e=0, ld_ac=0.
  - mem_addr shows the IR address field.
- IR opcode field bits beyond the top 3 are not decoded. The address field is IR[AWIDTH-1:0].

Optional Feature:
- Macro: ACCUM_CONTROLLER_RESUME_EN.
- Defined: adds input port resume (1 bit) after a_is_zero.
  - If halted and resume=1 at a clk edge: halted <= 0 and phase <= 0. Fetch continues at the current PC, which already points past the HLT.
  - resume while not halted is ignored.
  - rst has priority over resume.
- Undefined: no resume port; halt is left only via rst.

Test Plan:
- Reset, then run. rst=1 for 2 cycles; mem[0]=8'hA3 (LDA 3), mem[3]=8'h00. After 8 cycles: PC=1, ld_ac pulsed only in phase 7, opcode=5, mem_addr=3 in phases 4-7.
- SKZ skip. IR=8'h20 (SKZ), a_is_zero=1 in phase 6. Expect PC advances by 2 (4 -> 6). Repeat with a_is_zero=0: PC advances by 1 (4 -> 5).
- JMP. mem[2]=8'hFE (JMP 30). After that instruction PC=30; next phase-0 mem_addr=30. PC=31 plus a non-jump instruction wraps PC to 0.
- STO. IR=8'hC9 (STO 9). Expect data_e=1 in phases 6-7, mem_wr=1 only in phase 7, mem_addr=9, mem_rd=0 throughout phases 5-7.
- HLT. mem[4]=8'h00. Expect halt=1 from phase 4 and held; PC=5 frozen for 20 cycles; all strobes 0. With ACCUM_CONTROLLER_RESUME_EN, a resume pulse restarts fetch at address 5.
- Reset mid-instruction. Assert rst in phase 6 of an ADD. Next cycle: phase=0, PC=0, IR=0, ld_ac never pulses.

Source files
------------

// File: rtl/accum_controller.sv
// accum_controller: instruction sequencer for the 8-bit accumulator CPU.
// Owns PC, IR and an 8-phase cycle counter; decodes the IR opcode into
// memory strobes, accumulator load and bus-drive enables.
// Optional build macro ACCUM_CONTROLLER_RESUME_EN adds a `resume` input
// that restarts fetch after a HLT without a full reset.
// Debug outputs dbg_phase_o / dbg_pc_o expose the phase counter and PC.
module accum_controller #(
    parameter int WIDTH  = 8,
    parameter int AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              a_is_zero,
`ifdef ACCUM_CONTROLLER_RESUME_EN
    input  logic              resume,
`endif
    output logic [2:0]        opcode,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              data_e,
    output logic              ld_ac,
    output logic              halt,
    output logic [2:0]        dbg_phase_o,
    output logic [AWIDTH-1:0] dbg_pc_o
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    phase_t              phase_q, phase_d;
    logic [AWIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]    ir_q, ir_d;
    logic                halted_q, halted_d;
    logic                sel;
    logic                alu_op;
    logic                resume_req;
    logic [AWIDTH-1:0]   ir_addr;

`ifdef ACCUM_CONTROLLER_RESUME_EN
    assign resume_req = resume;
`else
    assign resume_req = 1'b0;
`endif

    assign opcode      = ir_q[WIDTH-1:WIDTH-3];
    assign ir_addr     = ir_q[AWIDTH-1:0];
    assign alu_op      = (opcode == OP_ADD) || (opcode == OP_AND) ||
                         (opcode == OP_XOR) || (opcode == OP_LDA);
    assign mem_addr    = sel ? pc_q : ir_addr;
    // halt rises combinationally in phase 4 of a HLT, before the flag registers.
    assign halt        = halted_q || ((phase_q == OP_ADDR) && (opcode == OP_HLT));
    assign dbg_phase_o = phase_q;
    assign dbg_pc_o    = pc_q;

    // State register: phase, PC, IR and halted flag; rst wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            pc_q     <= '0;
            ir_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end

    // Phase decode: strobes from phase and opcode, plus next PC/IR/halt state.
    always_comb begin
        phase_d  = phase_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        sel      = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        data_e   = 1'b0;
        ld_ac    = 1'b0;
        if (halted_q) begin
            // Frozen in OP_FETCH with all strobes low; only resume/rst exit.
            if (resume_req) begin
                halted_d = 1'b0;
                phase_d  = INST_ADDR;
            end
        end else begin
            phase_d = phase_t'(phase_q + 3'd1);
            case (phase_q)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel    = 1'b1;
                    mem_rd = 1'b1;
                end
                INST_LOAD: begin
                    sel    = 1'b1;
                    mem_rd = 1'b1;
                    ir_d   = mem_rdata;
                end
                IDLE: begin
                    sel    = 1'b1;
                    mem_rd = 1'b1;
                end
                OP_ADDR: begin
                    pc_d = pc_q + 1'b1;
                    if (opcode == OP_HLT) begin
                        halted_d = 1'b1;
                    end
                end
                OP_FETCH: begin
                    mem_rd = alu_op;
                end
                ALU_OP: begin
                    mem_rd = alu_op;
                    if ((opcode == OP_SKZ) && a_is_zero) begin
                        pc_d = pc_q + 1'b1;
                    end
                    if (opcode == OP_JMP) begin
                        pc_d = ir_addr;
                    end
                    if (opcode == OP_STO) begin
                        data_e = 1'b1;
                    end
                end
                STORE: begin
                    if (alu_op) begin
                        mem_rd = 1'b1;
                        ld_ac  = 1'b1;
                    end
                    if (opcode == OP_JMP) begin
                        pc_d = ir_addr;
                    end
                    if (opcode == OP_STO) begin
                        mem_wr = 1'b1;
                        data_e = 1'b1;
                    end
                end
                default: begin
                    phase_d = INST_ADDR;
                end
            endcase
        end
    end

endmodule
